// File: rtl/modop_pkg.sv
// Shared types and constants for the modular-add arbiter.
package modop_pkg;

    localparam int NREQ_DEF = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modadd.sv
// Pipelined (A+B) mod q with q = {qH, zeros, 1}; operands assumed < q.
// Optional register slices at input, after the add, and at the output.
module modadd #(
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 47,
    parameter int FF_IN  = 0,
    parameter int FF_ADD = 0,
    parameter int FF_OUT = 1
) (
    input  logic             clk,
    input  logic [LOGQ-1:0]  i_a,
    input  logic [LOGQ-1:0]  i_b,
    input  logic [LOGQH-1:0] i_qh,
    output logic [LOGQ-1:0]  o_c
);

    localparam int ZW = LOGQ - LOGQH - 1;

    logic [LOGQ-1:0]  w_a;
    logic [LOGQ-1:0]  w_b;
    logic [LOGQH-1:0] w_qh;
    logic [LOGQ-1:0]  w_q;
    logic [LOGQ:0]    w_sum;
    logic             w_ge;
    logic [LOGQ-1:0]  w_dif;
    logic             w_ge_s;
    logic [LOGQ-1:0]  w_sum_s;
    logic [LOGQ-1:0]  w_dif_s;
    logic [LOGQ-1:0]  w_c;

    if (ZW < 1) begin : g_bad_w
        $error("modadd: LOGQH must be at most LOGQ-2");
    end

    if (FF_IN != 0) begin : g_in_ff
        logic [LOGQ-1:0]  r_a;
        logic [LOGQ-1:0]  r_b;
        logic [LOGQH-1:0] r_qh;
        always_ff @(posedge clk) begin
            r_a  <= i_a;
            r_b  <= i_b;
            r_qh <= i_qh;
        end
        assign w_a  = r_a;
        assign w_b  = r_b;
        assign w_qh = r_qh;
    end else begin : g_in_comb
        assign w_a  = i_a;
        assign w_b  = i_b;
        assign w_qh = i_qh;
    end

    assign w_q   = {w_qh, {ZW{1'b0}}, 1'b1};
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    assign w_ge  = (w_sum >= {1'b0, w_q});
    // Only the low LOGQ bits matter: when sum >= q, sum-q < q fits.
    assign w_dif = w_sum[LOGQ-1:0] - w_q;

    if (FF_ADD != 0) begin : g_add_ff
        logic            r_ge;
        logic [LOGQ-1:0] r_sum;
        logic [LOGQ-1:0] r_dif;
        always_ff @(posedge clk) begin
            r_ge  <= w_ge;
            r_sum <= w_sum[LOGQ-1:0];
            r_dif <= w_dif;
        end
        assign w_ge_s  = r_ge;
        assign w_sum_s = r_sum;
        assign w_dif_s = r_dif;
    end else begin : g_add_comb
        assign w_ge_s  = w_ge;
        assign w_sum_s = w_sum[LOGQ-1:0];
        assign w_dif_s = w_dif;
    end

    assign w_c = w_ge_s ? w_dif_s : w_sum_s;

    if (FF_OUT != 0) begin : g_out_ff
        logic [LOGQ-1:0] r_c;
        always_ff @(posedge clk) begin
            r_c <= w_c;
        end
        assign o_c = r_c;
    end else begin : g_out_comb
        assign o_c = w_c;
    end

endmodule

// File: rtl/modadd_arb.sv
// Round-robin sharing of one modadd among NREQ requesters, with a
// drain-before-update guard on the qH configuration register.
module modadd_arb
    import modop_pkg::*;
#(
    parameter int               LOGQ    = 64,
    parameter int               LOGQH   = 47,
    parameter int               FF_IN   = 0,
    parameter int               FF_ADD  = 0,
    parameter int               FF_OUT  = 1,
    parameter int               NREQ    = NREQ_DEF,
    parameter logic [LOGQH-1:0] QH_INIT = '0,
    parameter int               IDW     = id_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*LOGQ-1:0] req_A,
    input  logic [NREQ*LOGQ-1:0] req_B,
    input  logic                 cfg_we,
    input  logic [LOGQH-1:0]     cfg_qH,
    output logic                 cfg_busy,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [LOGQ-1:0]      res_C
);

    localparam int LAT = FF_IN + FF_ADD + FF_OUT;

    if (LAT < 1 || LAT > 3) begin : g_bad_lat
        $error("modadd_arb: FF_IN+FF_ADD+FF_OUT must be 1..3");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("modadd_arb: NREQ must be 2..16");
    end

    arb_state_e       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [LOGQH-1:0] r_qh;
    logic [LOGQH-1:0] r_pend;
    logic             r_busy;
    logic [LAT-1:0]   r_tag_v;
    logic [IDW-1:0]   r_tag_id [LAT];

    logic [IDW:0]     w_cand;
    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic             w_grant_en;
    logic [NREQ-1:0]  w_ready;
    logic             w_fire;
    logic             w_inflight;
    logic [LOGQ-1:0]  w_a;
    logic [LOGQ-1:0]  w_b;
    logic [LOGQ-1:0]  w_c;

    // First valid index strictly after r_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(NREQ)) begin
                w_cand = w_cand - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IDW-1:0];
            end
        end
    end

    assign w_grant_en = (r_state == ST_RUN) & ~cfg_we & ~rst;
    assign w_ready    = (w_found && w_grant_en) ? (NREQ'(1) << w_win) : '0;
    assign w_fire     = |w_ready;
    assign w_inflight = |r_tag_v;
    assign req_ready  = w_ready;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_a = req_A[i*LOGQ +: LOGQ];
                w_b = req_B[i*LOGQ +: LOGQ];
            end
        end
    end

    modadd #(
        .LOGQ   (LOGQ),
        .LOGQH  (LOGQH),
        .FF_IN  (FF_IN),
        .FF_ADD (FF_ADD),
        .FF_OUT (FF_OUT)
    ) modadd_inst (
        .clk  (clk),
        .i_a  (w_a),
        .i_b  (w_b),
        .i_qh (r_qh),
        .o_c  (w_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_ptr   <= IDW'(NREQ - 1);
            r_qh    <= QH_INIT;
            r_pend  <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (w_fire) begin
                r_ptr <= w_win;
            end
            unique case (r_state)
                ST_RUN: begin
                    if (cfg_we && w_inflight) begin
                        r_pend  <= cfg_qH;
                        r_state <= ST_DRAIN;
                        r_busy  <= 1'b1;
                    end else if (cfg_we) begin
                        r_qh <= cfg_qH;
                    end
                end
                ST_DRAIN: begin
                    // A write landing on the final drain cycle wins.
                    if (!w_inflight) begin
                        r_qh    <= cfg_we ? cfg_qH : r_pend;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end else if (cfg_we) begin
                        r_pend <= cfg_qH;
                    end
                end
            endcase
        end
    end

    // Tag pipe is reset even though the datapath is not, so results
    // issued before a reset never surface.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_fire;
            r_tag_id[0] <= w_fire ? w_win : '0;
            for (int s = 1; s < LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    assign res_valid = r_tag_v[LAT-1] & ~rst;
    assign res_id    = rst ? '0 : r_tag_id[LAT-1];
    assign res_C     = res_valid ? w_c : '0;
    assign cfg_busy  = r_busy & ~rst;

endmodule

// File: tb/tb_modadd_arb.sv
// Randomized scoreboard bench for modadd_arb with a spec-level model.
module tb_modadd_arb;

    localparam int N   = 4;
    localparam int LQ  = 64;
    localparam int LQH = 47;
    localparam int LAT = 2;
    localparam logic [LQH-1:0] QH0 = 47'h400008C00000;

    typedef struct {
        int            id;
        logic [LQ-1:0] c;
        int            due;
    } exp_t;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*LQ-1:0]   req_A     = '0;
    logic [N*LQ-1:0]   req_B     = '0;
    logic              cfg_we    = 1'b0;
    logic [LQH-1:0]    cfg_qH    = '0;
    logic              cfg_busy;
    logic              res_valid;
    logic [1:0]        res_id;
    logic [LQ-1:0]     res_C;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    exp_t          sb [$];
    logic [LQ-1:0] opa [N];
    logic [LQ-1:0] opb [N];

    int            m_ptr  = N - 1;
    logic          m_drain = 1'b0;
    logic [LQH-1:0] m_qh  = '0;
    logic [LQH-1:0] m_pend = '0;
    int            m_last = -100;

    modadd_arb #(
        .LOGQ    (LQ),
        .LOGQH   (LQH),
        .FF_IN   (0),
        .FF_ADD  (1),
        .FF_OUT  (1),
        .NREQ    (N),
        .QH_INIT (47'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_A     (req_A),
        .req_B     (req_B),
        .cfg_we    (cfg_we),
        .cfg_qH    (cfg_qH),
        .cfg_busy  (cfg_busy),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_C     (res_C)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt++;

    function automatic logic [LQ:0] qof(input logic [LQH-1:0] qh);
        return {1'b0, qh, 16'd0, 1'b1};
    endfunction

    function automatic logic [LQ-1:0] addmod(input logic [LQ-1:0] a,
                                             input logic [LQ-1:0] b,
                                             input logic [LQH-1:0] qh);
        logic [LQ+1:0] s;
        logic [LQ+1:0] q;
        q = {1'b0, qof(qh)};
        s = {2'b00, a} + {2'b00, b};
        s = s % q;
        return s[LQ-1:0];
    endfunction

    function automatic logic [LQ-1:0] rnd_op(input logic [LQH-1:0] qh);
        logic [LQ:0] r;
        r = {1'b0, $urandom, $urandom};
        r = r % qof(qh);
        return r[LQ-1:0];
    endfunction

    task automatic step(input logic r, input logic [N-1:0] v,
                        input logic we, input logic [LQH-1:0] cq);
        logic [N-1:0] er;
        logic [1:0]   ix;
        int           win;
        logic         inflight;
        logic         eb;
        exp_t         e;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        cfg_we    = we;
        cfg_qH    = cq;
        for (int i = 0; i < N; i++) begin
            req_A[i*LQ +: LQ] = opa[i];
            req_B[i*LQ +: LQ] = opb[i];
        end
        #1;
        inflight = (m_last + LAT - 1 >= ecnt);
        win = -1;
        for (int k = 1; k <= N; k++) begin
            ix = 2'((m_ptr + k) % N);
            if (win < 0 && v[ix]) win = int'(ix);
        end
        er = '0;
        if (!r && !m_drain && !we && win >= 0) er[2'(win)] = 1'b1;
        eb = m_drain && !r;
        checks += 2;
        if (req_ready !== er) begin
            errors++;
            $display("FAIL ready t=%0t got %b want %b", $time, req_ready, er);
        end
        if (cfg_busy !== eb) begin
            errors++;
            $display("FAIL busy t=%0t got %b want %b", $time, cfg_busy, eb);
        end
        if (r) begin
            m_drain = 1'b0;
            m_ptr   = N - 1;
            m_qh    = '0;
            m_pend  = '0;
            m_last  = -100;
            sb.delete();
        end else if (!m_drain) begin
            if (we && inflight) begin
                m_pend  = cq;
                m_drain = 1'b1;
            end else if (we) begin
                m_qh = cq;
            end else if (win >= 0) begin
                e.id  = win;
                e.c   = addmod(opa[win], opb[win], m_qh);
                e.due = ecnt + LAT;
                sb.push_back(e);
                m_ptr  = win;
                m_last = ecnt + 1;
            end
        end else begin
            if (!inflight) begin
                m_qh    = we ? cq : m_pend;
                m_drain = 1'b0;
            end else if (we) begin
                m_pend = cq;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic zero_ops();
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
    endtask

    task automatic rnd_ops();
        for (int i = 0; i < N; i++) begin
            opa[i] = rnd_op(m_qh);
            opb[i] = rnd_op(m_qh);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is presented.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected t=%0t id %0d c %h", $time, res_id, res_C);
                end else begin
                    e = sb.pop_front();
                    if (int'(res_id) != e.id || res_C !== e.c || e.due != ecnt) begin
                        errors++;
                        $display("FAIL result t=%0t got id %0d c %h edge %0d want id %0d c %h edge %0d",
                                 $time, res_id, res_C, ecnt, e.id, e.c, e.due);
                    end
                end
            end else begin
                checks++;
                if (res_C !== '0) begin
                    errors++;
                    $display("FAIL idle_c t=%0t got %h want 0", $time, res_C);
                end
                if (sb.size() > 0 && sb[0].due <= ecnt) begin
                    errors++;
                    $display("FAIL missing t=%0t got none want id %0d c %h", $time, sb[0].id, sb[0].c);
                    e = sb.pop_front();
                end
            end
        end
    end

    initial begin
        zero_ops();
        step(1'b1, '0, 1'b0, '0);
        step(1'b1, 4'b1111, 1'b0, '0);
        step(1'b0, '0, 1'b1, QH0);

        opa[2] = 64'h010000000000000A;
        opb[2] = 64'h1000000000000005;
        step(1'b0, 4'b0100, 1'b0, '0);
        idle(LAT + 1);

        opa[1] = 64'h7FFFFFFFFFFFFFFF;
        opb[1] = 64'h7FFFFFFFFFFFFFFF;
        step(1'b0, 4'b0010, 1'b0, '0);
        idle(LAT + 1);

        step(1'b1, '0, 1'b0, '0);
        step(1'b0, '0, 1'b1, QH0);
        for (int i = 0; i < 8; i++) begin
            rnd_ops();
            step(1'b0, 4'b1111, 1'b0, '0);
        end
        idle(LAT + 1);

        rnd_ops();
        step(1'b0, 4'b1000, 1'b0, '0);
        zero_ops();
        step(1'b0, 4'b1000, 1'b1, '0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b1000, 1'b0, '0);
        idle(LAT + 1);

        step(1'b0, 4'b0001, 1'b1, QH0);
        rnd_ops();
        step(1'b0, 4'b0001, 1'b0, '0);
        idle(1);

        rnd_ops();
        step(1'b0, 4'b0001, 1'b0, '0);
        step(1'b1, '0, 1'b0, '0);
        idle(LAT + 2);
        zero_ops();
        step(1'b0, 4'b1111, 1'b0, '0);
        step(1'b0, 4'b1111, 1'b0, '0);
        idle(LAT + 1);
        step(1'b0, '0, 1'b1, QH0);

        for (int i = 0; i < 400; i++) begin
            logic           r;
            logic           we;
            logic [LQH-1:0] cq;
            r  = ($urandom % 150) == 0;
            we = ($urandom % 25) == 0;
            cq = {1'b1, 14'($urandom), 32'($urandom)};
            rnd_ops();
            step(r, 4'($urandom), we, cq);
        end
        idle(LAT + 4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
